// File: rtl/corelet_ctrl_if.sv
// -----------------------------------------------------------------------------
// corelet_ctrl_if
// Bundles the command/status signals of the corelet sequencer together with
// every handshake it exchanges with the activation SRAM, L0, the MAC array,
// the OFIFO and the psum SRAM.
//
// Parameters:
//   xaddr_w  activation SRAM address width
//   paddr_w  psum SRAM address width
//
// Modports:
//   master  the sequencer (corelet_ctrl): takes the command and corelet status,
//           drives busy/done and all SRAM/L0/OFIFO strobes
//   slave   the surrounding top level / corelet model
// -----------------------------------------------------------------------------
interface corelet_ctrl_if #(
    parameter int xaddr_w = 11,
    parameter int paddr_w = 11
);
    logic               start;
    logic               mode;
    logic [7:0]         num_vec;
    logic [xaddr_w-1:0] x_base;
    logic [paddr_w-1:0] p_base;
    logic               busy;
    logic               done;
    logic               xmem_cen;
    logic [xaddr_w-1:0] xmem_addr;
    logic               l0_wr;
    logic               l0_rd;
    logic               l0_o_full;
    logic [1:0]         inst;
    logic               ofifo_rd;
    logic               ofifo_o_valid;
    logic               pmem_wen;
    logic [paddr_w-1:0] pmem_addr;

    modport master (
        input  start, mode, num_vec, x_base, p_base, l0_o_full, ofifo_o_valid,
        output busy, done, xmem_cen, xmem_addr, l0_wr, l0_rd, inst,
               ofifo_rd, pmem_wen, pmem_addr
    );

    modport slave (
        output start, mode, num_vec, x_base, p_base, l0_o_full, ofifo_o_valid,
        input  busy, done, xmem_cen, xmem_addr, l0_wr, l0_rd, inst,
               ofifo_rd, pmem_wen, pmem_addr
    );
endinterface

// File: rtl/corelet_ctrl.sv
// -----------------------------------------------------------------------------
// corelet_ctrl
// Memory-side sequencer for one corelet. A single start runs one pass:
//   kernel load (mode 0): activation SRAM -> L0 -> MAC array with inst 01,
//                         then row+col settle cycles
//   execute     (mode 1): activation SRAM -> L0 -> MAC array with inst 10,
//                         then drain num_vec OFIFO rows into the psum SRAM
// Every pass ends with a one-cycle done pulse. All outputs are registered.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low
//   bus    corelet_ctrl_if.master
//          in : start, mode, num_vec, x_base, p_base, l0_o_full, ofifo_o_valid
//          out: busy, done, xmem_cen (act-low), xmem_addr, l0_wr, l0_rd, inst,
//               ofifo_rd, pmem_wen (act-low), pmem_addr
// -----------------------------------------------------------------------------
module corelet_ctrl #(
    parameter int bw       = 4,
    parameter int psum_bw  = 16,
    parameter int row      = 8,
    parameter int col      = 8,
    parameter int l0_depth = 64,
    parameter int xaddr_w  = 11,
    parameter int paddr_w  = 11
) (
    input logic            clk,
    input logic            reset,
    corelet_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        STREAM,
        FLUSH,
        DRAIN,
        DONE
    } state_t;

    localparam logic [7:0] FLUSH_LAST = 8'(row + col - 1);

    // The data-path widths and L0 depth only describe the instance; a
    // degenerate configuration shows up as this marker scope in the hierarchy.
    if (bw < 1 || psum_bw < 1 || l0_depth < 2 || row < 1 || col < 1) begin : g_degenerate_config
    end

    state_t             state;
    logic [7:0]         cnt;
    logic               mode_q;
    logic [7:0]         num_q;
    logic [xaddr_w-1:0] x_base_q;
    logic [paddr_w-1:0] p_base_q;

    // Pass sequencer. cnt is reused per phase: reads issued in FILL, L0 reads
    // in STREAM, settle cycles in FLUSH, OFIFO reads in DRAIN. Strobes default
    // to idle every cycle and are re-asserted by the state that owns them,
    // while addresses simply hold. Decisions on l0_o_full / ofifo_o_valid are
    // made at the edge that opens the cycle carrying the strobe, so the first
    // SRAM read is already issued on the edge that accepts start, and the first
    // OFIFO read may be issued on the edge that enters DRAIN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= 8'd0;
            mode_q        <= 1'b0;
            num_q         <= 8'd0;
            x_base_q      <= '0;
            p_base_q      <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.xmem_cen  <= 1'b1;
            bus.xmem_addr <= '0;
            bus.l0_wr     <= 1'b0;
            bus.l0_rd     <= 1'b0;
            bus.inst      <= 2'b00;
            bus.ofifo_rd  <= 1'b0;
            bus.pmem_wen  <= 1'b1;
            bus.pmem_addr <= '0;
        end else begin
            bus.done     <= 1'b0;
            bus.xmem_cen <= 1'b1;
            bus.l0_wr    <= 1'b0;
            bus.l0_rd    <= 1'b0;
            bus.inst     <= 2'b00;
            bus.ofifo_rd <= 1'b0;
            bus.pmem_wen <= 1'b1;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mode_q   <= bus.mode;
                        num_q    <= bus.num_vec;
                        x_base_q <= bus.x_base;
                        p_base_q <= bus.p_base;
                        bus.busy <= 1'b1;
                        cnt      <= 8'd0;
                        if (bus.num_vec == 8'd0) begin
                            state    <= DONE;
                            bus.done <= 1'b1;
                        end else begin
                            state <= FILL;
                            if (!bus.l0_o_full) begin
                                bus.xmem_cen  <= 1'b0;
                                bus.xmem_addr <= bus.x_base;
                                cnt           <= 8'd1;
                            end
                        end
                    end
                end
                FILL: begin
                    // SRAM data lands one cycle after the read, so the L0 write
                    // follows every issued read regardless of a new stall.
                    bus.l0_wr <= ~bus.xmem_cen;
                    if (cnt == num_q && bus.xmem_cen) begin
                        state     <= STREAM;
                        bus.l0_rd <= 1'b1;
                        bus.inst  <= mode_q ? 2'b10 : 2'b01;
                        cnt       <= 8'd1;
                    end else if (cnt != num_q && !bus.l0_o_full) begin
                        bus.xmem_cen  <= 1'b0;
                        bus.xmem_addr <= x_base_q + xaddr_w'(cnt);
                        cnt           <= cnt + 8'd1;
                    end
                end
                STREAM: begin
                    if (cnt == num_q) begin
                        cnt   <= 8'd0;
                        state <= mode_q ? DRAIN : FLUSH;
                        if (mode_q && bus.ofifo_o_valid) begin
                            bus.ofifo_rd  <= 1'b1;
                            bus.pmem_wen  <= 1'b0;
                            bus.pmem_addr <= p_base_q;
                            cnt           <= 8'd1;
                        end
                    end else begin
                        bus.l0_rd <= 1'b1;
                        bus.inst  <= mode_q ? 2'b10 : 2'b01;
                        cnt       <= cnt + 8'd1;
                    end
                end
                FLUSH: begin
                    if (cnt == FLUSH_LAST) begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DRAIN: begin
                    if (cnt == num_q) begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                    end else if (bus.ofifo_o_valid) begin
                        bus.ofifo_rd  <= 1'b1;
                        bus.pmem_wen  <= 1'b0;
                        bus.pmem_addr <= p_base_q + paddr_w'(cnt);
                        cnt           <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_corelet_ctrl.sv
// -----------------------------------------------------------------------------
// tb_corelet_ctrl
// Self-checking bench for corelet_ctrl. A schedule model derived from the pass
// description (read/write/stream/flush/drain cycle lists) predicts every
// output per cycle; each test task drives a pass, captures the DUT outputs at
// the falling edge, and compares them against the model plus a few fixed
// values from the worked examples.
// Cycle numbering: cycle 0 holds start; an input value listed "in cycle k" is
// the value present at the rising edge that opens cycle k.
// -----------------------------------------------------------------------------
module tb_corelet_ctrl;

    localparam int XW        = 11;
    localparam int PW        = 11;
    localparam int FLUSH_LEN = 16;
    localparam int MAXC      = 1024;

    localparam int B_BUSY = 8;
    localparam int B_DONE = 7;
    localparam int B_CEN  = 6;
    localparam int B_WR   = 5;
    localparam int B_RD   = 4;
    localparam int B_INST = 2;
    localparam int B_OFRD = 1;
    localparam int B_WEN  = 0;

    localparam logic [8:0] IDLE_CTRL = 9'b001000001;

    logic clk = 1'b0;
    logic reset;

    corelet_ctrl_if #(.xaddr_w(XW), .paddr_w(PW)) bus ();

    corelet_ctrl #(
        .bw(4), .psum_bw(16), .row(8), .col(8), .l0_depth(64),
        .xaddr_w(XW), .paddr_w(PW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    bit             full_pat  [MAXC];
    bit             valid_pat [MAXC];
    logic [8:0]     exp_ctrl  [MAXC];
    logic [XW-1:0]  exp_xaddr [MAXC];
    logic [PW-1:0]  exp_paddr [MAXC];
    logic [8:0]     act_ctrl  [MAXC];
    logic [XW-1:0]  act_xaddr [MAXC];
    logic [PW-1:0]  act_paddr [MAXC];
    int             exp_done_c;
    int             run_len;

    task automatic clear_patterns();
        for (int i = 0; i < MAXC; i++) begin
            full_pat[i]  = 1'b0;
            valid_pat[i] = 1'b0;
        end
    endtask

    task automatic random_patterns(input int full_pct, input int valid_pct);
        for (int i = 0; i < MAXC; i++) begin
            full_pat[i]  = (i < 300) && ($urandom_range(0, 99) < full_pct);
            valid_pat[i] = (i >= 600) || ($urandom_range(0, 99) < valid_pct);
        end
    endtask

    // Schedule model: list the cycles of each activity from the pass rules.
    task automatic build_model(input int n, input bit m,
                               input logic [XW-1:0] xb, input logic [PW-1:0] pb);
        int issued;
        int drained;
        int last;
        int c;
        int s;
        for (int i = 0; i < MAXC; i++) begin
            exp_ctrl[i]  = IDLE_CTRL;
            exp_xaddr[i] = '0;
            exp_paddr[i] = '0;
        end
        if (n == 0) begin
            exp_done_c = 1;
        end else begin
            issued = 0;
            last   = 0;
            c      = 1;
            while (issued < n && c < 700) begin
                if (!full_pat[c]) begin
                    exp_ctrl[c][B_CEN]   = 1'b0;
                    exp_xaddr[c]         = xb + XW'(issued);
                    exp_ctrl[c+1][B_WR]  = 1'b1;
                    issued++;
                    last = c;
                end
                c++;
            end
            s = last + 2;
            for (int k = 0; k < n; k++) begin
                exp_ctrl[s+k][B_RD]       = 1'b1;
                exp_ctrl[s+k][B_INST +: 2] = m ? 2'b10 : 2'b01;
            end
            if (!m) begin
                exp_done_c = s + n + FLUSH_LEN;
            end else begin
                drained = 0;
                c = s + n;
                while (drained < n && c < MAXC - 4) begin
                    if (valid_pat[c]) begin
                        exp_ctrl[c][B_OFRD] = 1'b1;
                        exp_ctrl[c][B_WEN]  = 1'b0;
                        exp_paddr[c]        = pb + PW'(drained);
                        drained++;
                        last = c;
                    end
                    c++;
                end
                exp_done_c = last + 1;
            end
        end
        for (int i = 1; i <= exp_done_c; i++) exp_ctrl[i][B_BUSY] = 1'b1;
        exp_ctrl[exp_done_c][B_DONE] = 1'b1;
    endtask

    // Drives one pass starting in the current cycle (entered at a falling
    // edge in IDLE) and records the outputs of cycles 1..run_len.
    task automatic run_pass(input int n, input bit m, input logic [XW-1:0] xb,
                            input logic [PW-1:0] pb, input bit pulse, input int abort_c);
        build_model(n, m, xb, pb);
        run_len = exp_done_c + 1;
        if (abort_c > 0 && abort_c < run_len) run_len = abort_c;
        bus.start         = 1'b1;
        bus.mode          = m;
        bus.num_vec       = 8'(n);
        bus.x_base        = xb;
        bus.p_base        = pb;
        bus.l0_o_full     = full_pat[1];
        bus.ofifo_o_valid = valid_pat[1];
        for (int c = 1; c <= run_len; c++) begin
            @(negedge clk);
            act_ctrl[c]  = {bus.busy, bus.done, bus.xmem_cen, bus.l0_wr, bus.l0_rd,
                            bus.inst, bus.ofifo_rd, bus.pmem_wen};
            act_xaddr[c] = bus.xmem_addr;
            act_paddr[c] = bus.pmem_addr;
            if (pulse && c <= exp_done_c) begin
                bus.start   = 1'($urandom_range(0, 1));
                bus.mode    = 1'($urandom_range(0, 1));
                bus.num_vec = 8'($urandom);
                bus.x_base  = XW'($urandom);
                bus.p_base  = PW'($urandom);
            end else begin
                bus.start = 1'b0;
            end
            bus.l0_o_full     = full_pat[c+1];
            bus.ofifo_o_valid = valid_pat[c+1];
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.mode = 1'b0; bus.num_vec = 8'd0;
        bus.x_base = '0; bus.p_base = '0;
        bus.l0_o_full = 1'b0; bus.ofifo_o_valid = 1'b0;
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({bus.busy, bus.done, bus.xmem_cen, bus.l0_wr, bus.l0_rd, bus.inst,
             bus.ofifo_rd, bus.pmem_wen} !== IDLE_CTRL) begin
            n_fail++;
            $display("[TB] FAIL reset_ctrl: got %b, expected %b",
                     {bus.busy, bus.done, bus.xmem_cen, bus.l0_wr, bus.l0_rd, bus.inst,
                      bus.ofifo_rd, bus.pmem_wen}, IDLE_CTRL);
        end
        n_checks++;
        if (bus.xmem_addr !== '0 || bus.pmem_addr !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_addr: got x=%h p=%h, expected 0/0", bus.xmem_addr, bus.pmem_addr);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.done, bus.xmem_cen, bus.l0_wr, bus.l0_rd, bus.inst,
             bus.ofifo_rd, bus.pmem_wen} !== IDLE_CTRL) begin
            n_fail++;
            $display("[TB] FAIL idle_after_reset: got %b, expected %b",
                     {bus.busy, bus.done, bus.xmem_cen, bus.l0_wr, bus.l0_rd, bus.inst,
                      bus.ofifo_rd, bus.pmem_wen}, IDLE_CTRL);
        end
    endtask

    task automatic test_kernel_load();
        clear_patterns();
        run_pass(8, 1'b0, 11'h010, 11'h000, 1'b0, 0);
        for (int c = 1; c <= run_len; c++) begin
            n_checks++;
            if (act_ctrl[c] !== exp_ctrl[c]) begin
                n_fail++;
                $display("[TB] FAIL kernel_load ctrl c%0d: got %b, expected %b", c, act_ctrl[c], exp_ctrl[c]);
            end
            if (exp_ctrl[c][B_CEN] == 1'b0) begin
                n_checks++;
                if (act_xaddr[c] !== exp_xaddr[c]) begin
                    n_fail++;
                    $display("[TB] FAIL kernel_load xaddr c%0d: got %h, expected %h", c, act_xaddr[c], exp_xaddr[c]);
                end
            end
        end
        n_checks++;
        if (act_ctrl[34][B_DONE] !== 1'b1 || act_xaddr[1] !== 11'h010 || act_xaddr[8] !== 11'h017 ||
            act_ctrl[17][B_INST +: 2] !== 2'b01 || act_ctrl[18][B_RD] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL kernel_load anchors: done34=%b x1=%h x8=%h inst17=%b rd18=%b, expected 1 010 017 01 0",
                     act_ctrl[34][B_DONE], act_xaddr[1], act_xaddr[8], act_ctrl[17][B_INST +: 2], act_ctrl[18][B_RD]);
        end
    endtask

    task automatic test_execute();
        clear_patterns();
        for (int i = 12; i < MAXC; i++) valid_pat[i] = 1'b1;
        run_pass(4, 1'b1, 11'h7FE, 11'h100, 1'b0, 0);
        for (int c = 1; c <= run_len; c++) begin
            n_checks++;
            if (act_ctrl[c] !== exp_ctrl[c]) begin
                n_fail++;
                $display("[TB] FAIL execute ctrl c%0d: got %b, expected %b", c, act_ctrl[c], exp_ctrl[c]);
            end
            if (exp_ctrl[c][B_CEN] == 1'b0) begin
                n_checks++;
                if (act_xaddr[c] !== exp_xaddr[c]) begin
                    n_fail++;
                    $display("[TB] FAIL execute xaddr c%0d: got %h, expected %h", c, act_xaddr[c], exp_xaddr[c]);
                end
            end
            if (exp_ctrl[c][B_WEN] == 1'b0) begin
                n_checks++;
                if (act_paddr[c] !== exp_paddr[c]) begin
                    n_fail++;
                    $display("[TB] FAIL execute paddr c%0d: got %h, expected %h", c, act_paddr[c], exp_paddr[c]);
                end
            end
        end
        n_checks++;
        if (act_ctrl[16][B_DONE] !== 1'b1 || act_paddr[12] !== 11'h100 || act_paddr[15] !== 11'h103 ||
            act_xaddr[3] !== 11'h000 || act_ctrl[6][B_INST +: 2] !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL execute anchors: done16=%b p12=%h p15=%h x3=%h inst6=%b, expected 1 100 103 000 10",
                     act_ctrl[16][B_DONE], act_paddr[12], act_paddr[15], act_xaddr[3], act_ctrl[6][B_INST +: 2]);
        end
    endtask

    task automatic test_fill_stall();
        clear_patterns();
        for (int i = 3; i <= 5; i++) full_pat[i] = 1'b1;
        run_pass(8, 1'b0, 11'h200, 11'h000, 1'b0, 0);
        for (int c = 1; c <= run_len; c++) begin
            n_checks++;
            if (act_ctrl[c] !== exp_ctrl[c]) begin
                n_fail++;
                $display("[TB] FAIL fill_stall ctrl c%0d: got %b, expected %b", c, act_ctrl[c], exp_ctrl[c]);
            end
            if (exp_ctrl[c][B_CEN] == 1'b0) begin
                n_checks++;
                if (act_xaddr[c] !== exp_xaddr[c]) begin
                    n_fail++;
                    $display("[TB] FAIL fill_stall xaddr c%0d: got %h, expected %h", c, act_xaddr[c], exp_xaddr[c]);
                end
            end
        end
        n_checks++;
        if (act_ctrl[4][B_CEN] !== 1'b1 || act_ctrl[6][B_CEN] !== 1'b0 || act_xaddr[6] !== 11'h202 ||
            act_ctrl[37][B_DONE] !== 1'b1 || act_ctrl[13][B_RD] !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL fill_stall anchors: cen4=%b cen6=%b x6=%h done37=%b rd13=%b, expected 1 0 202 1 1",
                     act_ctrl[4][B_CEN], act_ctrl[6][B_CEN], act_xaddr[6], act_ctrl[37][B_DONE], act_ctrl[13][B_RD]);
        end
    endtask

    task automatic test_zero_vectors();
        random_patterns(30, 50);
        run_pass(0, 1'($urandom_range(0, 1)), XW'($urandom), PW'($urandom), 1'b0, 0);
        for (int c = 1; c <= run_len; c++) begin
            n_checks++;
            if (act_ctrl[c] !== exp_ctrl[c]) begin
                n_fail++;
                $display("[TB] FAIL zero_vectors ctrl c%0d: got %b, expected %b", c, act_ctrl[c], exp_ctrl[c]);
            end
        end
        n_checks++;
        if (act_ctrl[1] !== 9'b111000001 || act_ctrl[2][B_BUSY] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL zero_vectors anchors: c1=%b busy2=%b, expected 111000001 0",
                     act_ctrl[1], act_ctrl[2][B_BUSY]);
        end
    endtask

    task automatic test_start_ignored();
        for (int p = 0; p < 2; p++) begin
            random_patterns(20, 60);
            run_pass(10, 1'(p), XW'($urandom), PW'($urandom), 1'b1, 0);
            for (int c = 1; c <= run_len; c++) begin
                n_checks++;
                if (act_ctrl[c] !== exp_ctrl[c]) begin
                    n_fail++;
                    $display("[TB] FAIL start_ignored ctrl p%0d c%0d: got %b, expected %b", p, c, act_ctrl[c], exp_ctrl[c]);
                end
                if (exp_ctrl[c][B_CEN] == 1'b0 && act_xaddr[c] !== exp_xaddr[c]) begin
                    n_fail++;
                    $display("[TB] FAIL start_ignored xaddr p%0d c%0d: got %h, expected %h", p, c, act_xaddr[c], exp_xaddr[c]);
                end
                if (exp_ctrl[c][B_WEN] == 1'b0 && act_paddr[c] !== exp_paddr[c]) begin
                    n_fail++;
                    $display("[TB] FAIL start_ignored paddr p%0d c%0d: got %h, expected %h", p, c, act_paddr[c], exp_paddr[c]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        logic [8:0] snap;
        clear_patterns();
        for (int i = 12; i < MAXC; i++) valid_pat[i] = 1'b1;
        run_pass(4, 1'b1, 11'h020, 11'h100, 1'b0, 13);
        n_checks++;
        if (act_ctrl[13][B_OFRD] !== 1'b1 || act_paddr[13] !== 11'h101) begin
            n_fail++;
            $display("[TB] FAIL pre_reset_drain: ofifo_rd=%b paddr=%h, expected 1 101",
                     act_ctrl[13][B_OFRD], act_paddr[13]);
        end
        reset = 1'b0;
        #1;
        snap = {bus.busy, bus.done, bus.xmem_cen, bus.l0_wr, bus.l0_rd, bus.inst,
                bus.ofifo_rd, bus.pmem_wen};
        n_checks++;
        if (snap !== IDLE_CTRL) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_drain: got %b, expected %b", snap, IDLE_CTRL);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_pass(4, 1'b1, 11'h020, 11'h100, 1'b0, 0);
        for (int c = 1; c <= run_len; c++) begin
            n_checks++;
            if (act_ctrl[c] !== exp_ctrl[c]) begin
                n_fail++;
                $display("[TB] FAIL post_reset_pass ctrl c%0d: got %b, expected %b", c, act_ctrl[c], exp_ctrl[c]);
            end
            if (exp_ctrl[c][B_WEN] == 1'b0 && act_paddr[c] !== exp_paddr[c]) begin
                n_fail++;
                $display("[TB] FAIL post_reset_pass paddr c%0d: got %h, expected %h", c, act_paddr[c], exp_paddr[c]);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int p = 0; p < 3; p++) begin
            random_patterns(25, 50);
            run_pass($urandom_range(1, 20), 1'($urandom_range(0, 1)), XW'($urandom), PW'($urandom), 1'b0, 0);
            for (int c = 1; c <= run_len; c++) begin
                n_checks++;
                if (act_ctrl[c] !== exp_ctrl[c]) begin
                    n_fail++;
                    $display("[TB] FAIL back_to_back ctrl p%0d c%0d: got %b, expected %b", p, c, act_ctrl[c], exp_ctrl[c]);
                end
                if (exp_ctrl[c][B_CEN] == 1'b0 && act_xaddr[c] !== exp_xaddr[c]) begin
                    n_fail++;
                    $display("[TB] FAIL back_to_back xaddr p%0d c%0d: got %h, expected %h", p, c, act_xaddr[c], exp_xaddr[c]);
                end
                if (exp_ctrl[c][B_WEN] == 1'b0 && act_paddr[c] !== exp_paddr[c]) begin
                    n_fail++;
                    $display("[TB] FAIL back_to_back paddr p%0d c%0d: got %h, expected %h", p, c, act_paddr[c], exp_paddr[c]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int p = 0; p < 8; p++) begin
            random_patterns($urandom_range(0, 50), $urandom_range(20, 90));
            run_pass($urandom_range(0, 63), 1'($urandom_range(0, 1)), XW'($urandom), PW'($urandom), 1'b0, 0);
            for (int c = 1; c <= run_len; c++) begin
                n_checks++;
                if (act_ctrl[c] !== exp_ctrl[c]) begin
                    n_fail++;
                    $display("[TB] FAIL random ctrl p%0d c%0d: got %b, expected %b", p, c, act_ctrl[c], exp_ctrl[c]);
                end
                if (exp_ctrl[c][B_CEN] == 1'b0 && act_xaddr[c] !== exp_xaddr[c]) begin
                    n_fail++;
                    $display("[TB] FAIL random xaddr p%0d c%0d: got %h, expected %h", p, c, act_xaddr[c], exp_xaddr[c]);
                end
                if (exp_ctrl[c][B_WEN] == 1'b0 && act_paddr[c] !== exp_paddr[c]) begin
                    n_fail++;
                    $display("[TB] FAIL random paddr p%0d c%0d: got %h, expected %h", p, c, act_paddr[c], exp_paddr[c]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_kernel_load();
        test_execute();
        test_fill_stall();
        test_zero_vectors();
        test_start_ignored();
        test_reset_mid_drain();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
